// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: serial HI/LO sequencer executing MULT/MULTU/DIV/DIVU/MTHI/MTLO lanes in program order.
// Build option MUL_FAST_EN: single-cycle multiplier instead of the iterative shift-add unit.
module ex_muldiv_seq #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      bundle_valid_i,
    input  logic [3*NUM_LANES-1:0]    lane_op_i,
    input  logic [XLEN*NUM_LANES-1:0] lane_opa_i,
    input  logic [XLEN*NUM_LANES-1:0] lane_opb_i,
    output logic [XLEN-1:0]           hi_o,
    output logic [XLEN-1:0]           lo_o,
    output logic                      busy_o,
    output logic                      stallreq_o,
    output logic                      done_o
);
    // state | meaning
    // IDLE  | waiting; fast-path MT commit; accepting a bundle runs the first slot's first cycle
    // SLOT  | first cycle of the next non-NOP lane (MT commits here, mul/div load here)
    // MUL   | remaining shift-add iterations
    // DIV   | remaining restoring-divide iterations
    // FIX   | divide sign correction and commit
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SLOT = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [2:0]  LANE_NONE = 3'(NUM_LANES);
    localparam int          CW        = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    function automatic logic is_work(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic logic is_md(input logic [2:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // lowest working lane at or above start; LANE_NONE if there is none
    function automatic logic [2:0] find_lane(input logic [3*NUM_LANES-1:0] ops,
                                             input logic [2:0] start);
        logic [2:0] r;
        r = LANE_NONE;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if ((3'(k) >= start) && is_work(ops[3*k +: 3])) r = 3'(k);
        end
        return r;
    endfunction

    logic [2:0]                state_q;
    logic [2:0]                lane_q;
    logic [CW-1:0]             cnt_q;
    logic [3*NUM_LANES-1:0]    b_op_q;
    logic [XLEN*NUM_LANES-1:0] b_opa_q;
    logic [XLEN*NUM_LANES-1:0] b_opb_q;
    logic [XLEN-1:0]           hi_q;
    logic [XLEN-1:0]           lo_q;
    logic [XLEN-1:0]           rem_q;
    logic [XLEN-1:0]           quo_q;
    logic [XLEN-1:0]           dvs_q;
    logic                      neg_q_q;
    logic                      neg_r_q;
`ifndef MUL_FAST_EN
    logic [2*XLEN-1:0]         prod_q;
    logic [XLEN-1:0]           mcand_q;
    logic                      neg_p_q;
`endif

    logic                      idle;
    logic                      in_has_md;
    logic                      accept;
    logic                      active;
    logic                      dispatch;
    logic                      fast_mt;
    logic [XLEN-1:0]           fast_hi;
    logic [XLEN-1:0]           fast_lo;
    logic [3*NUM_LANES-1:0]    ops_sel;
    logic [XLEN*NUM_LANES-1:0] opa_sel;
    logic [XLEN*NUM_LANES-1:0] opb_sel;
    logic [2:0]                cur_lane;
    logic [2:0]                nxt_lane;
    logic                      has_next;
    logic [2:0]                cur_op;
    logic [XLEN-1:0]           cur_a;
    logic [XLEN-1:0]           cur_b;
    logic                      cur_is_mt;
    logic                      cur_is_mul;
    logic                      cur_is_div;
    logic                      op_signed;
    logic                      sgn_a;
    logic                      sgn_b;
    logic [XLEN-1:0]           mag_a;
    logic [XLEN-1:0]           mag_b;
    logic [XLEN-1:0]           d_rem_in;
    logic [XLEN-1:0]           d_quo_in;
    logic [XLEN-1:0]           d_dvs_in;
    logic [XLEN:0]             d_shift;
    logic                      d_ge;
    logic [XLEN-1:0]           d_sub;
    logic [XLEN-1:0]           rem_nxt;
    logic [XLEN-1:0]           quo_nxt;
    logic [XLEN-1:0]           div_hi;
    logic [XLEN-1:0]           div_lo;
    logic [2*XLEN-1:0]         mul_res;
`ifndef MUL_FAST_EN
    logic [2*XLEN-1:0]         m_prod_in;
    logic [XLEN-1:0]           m_mcand_in;
    logic [XLEN:0]             m_sum;
    logic [2*XLEN-1:0]         prod_nxt;
`endif
    logic                      slot_done;
    logic                      last_cycle;

    always_comb begin
        idle      = (state_q == S_IDLE);
        in_has_md = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (is_md(lane_op_i[3*k +: 3])) in_has_md = 1'b1;
        end
        accept   = idle && bundle_valid_i && in_has_md && !flush_i && !rst;
        active   = accept || (!idle && !flush_i && !rst);
        dispatch = accept || ((state_q == S_SLOT) && active);
        fast_mt  = idle && bundle_valid_i && !in_has_md && !flush_i && !rst;

        // fast path: later lanes overwrite earlier ones
        fast_hi = hi_q;
        fast_lo = lo_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_op_i[3*k +: 3] == OP_MTHI) fast_hi = lane_opa_i[XLEN*k +: XLEN];
            else if (lane_op_i[3*k +: 3] == OP_MTLO) fast_lo = lane_opa_i[XLEN*k +: XLEN];
        end

        // the acceptance cycle works straight off the lane inputs
        ops_sel  = idle ? lane_op_i  : b_op_q;
        opa_sel  = idle ? lane_opa_i : b_opa_q;
        opb_sel  = idle ? lane_opb_i : b_opb_q;
        cur_lane = idle ? find_lane(lane_op_i, 3'd0) : lane_q;
        cur_op   = 3'd0;
        cur_a    = '0;
        cur_b    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (3'(k) == cur_lane) begin
                cur_op = ops_sel[3*k +: 3];
                cur_a  = opa_sel[XLEN*k +: XLEN];
                cur_b  = opb_sel[XLEN*k +: XLEN];
            end
        end
        nxt_lane = find_lane(ops_sel, cur_lane + 3'd1);
        has_next = (nxt_lane != LANE_NONE);

        cur_is_mt  = (cur_op == OP_MTHI) || (cur_op == OP_MTLO);
        cur_is_mul = (cur_op == OP_MULT) || (cur_op == OP_MULTU);
        cur_is_div = (cur_op == OP_DIV)  || (cur_op == OP_DIVU);
        op_signed  = (cur_op == OP_MULT) || (cur_op == OP_DIV);
        sgn_a      = op_signed && cur_a[XLEN-1];
        sgn_b      = op_signed && cur_b[XLEN-1];
        mag_a      = sgn_a ? -cur_a : cur_a;
        mag_b      = sgn_b ? -cur_b : cur_b;

        // restoring divide step on magnitudes; a zero divisor yields all-ones quotient, remainder |a|
        d_rem_in = dispatch ? '0    : rem_q;
        d_quo_in = dispatch ? mag_a : quo_q;
        d_dvs_in = dispatch ? mag_b : dvs_q;
        d_shift  = {d_rem_in, d_quo_in[XLEN-1]};
        d_ge     = (d_shift >= {1'b0, d_dvs_in});
        d_sub    = d_shift[XLEN-1:0] - d_dvs_in;
        rem_nxt  = d_ge ? d_sub : d_shift[XLEN-1:0];
        quo_nxt  = {d_quo_in[XLEN-2:0], d_ge};
        div_lo   = neg_q_q ? -quo_q : quo_q;
        div_hi   = neg_r_q ? -rem_q : rem_q;

`ifdef MUL_FAST_EN
        mul_res = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (sgn_a ^ sgn_b) mul_res = -mul_res;
`else
        m_prod_in  = dispatch ? {{XLEN{1'b0}}, mag_b} : prod_q;
        m_mcand_in = dispatch ? mag_a : mcand_q;
        m_sum      = {1'b0, m_prod_in[2*XLEN-1:XLEN]}
                   + (m_prod_in[0] ? {1'b0, m_mcand_in} : {(XLEN+1){1'b0}});
        prod_nxt   = {m_sum, m_prod_in[XLEN-1:1]};
        mul_res    = neg_p_q ? -prod_nxt : prod_nxt;
`endif

        slot_done = active && ((dispatch && cur_is_mt)
`ifdef MUL_FAST_EN
                    || (dispatch && cur_is_mul)
`else
                    || ((state_q == S_MUL) && (cnt_q == '0))
`endif
                    || (state_q == S_FIX));
        last_cycle = slot_done && !has_next;
    end

    assign stallreq_o = active;
    assign done_o     = last_cycle;
    assign busy_o     = !idle;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= 3'd0;
            cnt_q   <= '0;
            b_op_q  <= '0;
            b_opa_q <= '0;
            b_opb_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`ifndef MUL_FAST_EN
            prod_q  <= '0;
            mcand_q <= '0;
            neg_p_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                b_op_q  <= lane_op_i;
                b_opa_q <= lane_opa_i;
                b_opb_q <= lane_opb_i;
            end

            if (!active) begin
                state_q <= S_IDLE;
            end else if (slot_done) begin
                state_q <= has_next ? S_SLOT : S_IDLE;
                lane_q  <= has_next ? nxt_lane : 3'd0;
            end else if (dispatch) begin
                state_q <= cur_is_mul ? S_MUL : S_DIV;
                lane_q  <= cur_lane;
                cnt_q   <= CNT_LAST - 1'b1;
            end else if ((state_q == S_DIV) && (cnt_q == '0)) begin
                state_q <= S_FIX;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (active && cur_is_div && (dispatch || (state_q == S_DIV))) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                dvs_q <= d_dvs_in;
            end
            // quotient sign is left alone on divide-by-zero so LO stays all ones
            if (dispatch && cur_is_div) begin
                neg_q_q <= (sgn_a ^ sgn_b) && (cur_b != '0);
                neg_r_q <= sgn_a;
            end
`ifndef MUL_FAST_EN
            if (active && cur_is_mul && (dispatch || (state_q == S_MUL))) begin
                prod_q  <= prod_nxt;
                mcand_q <= m_mcand_in;
            end
            if (dispatch && cur_is_mul) neg_p_q <= sgn_a ^ sgn_b;
`endif

            if (fast_mt) begin
                hi_q <= fast_hi;
                lo_q <= fast_lo;
            end else if (slot_done) begin
                if (cur_op == OP_MTHI)       hi_q <= cur_a;
                else if (cur_op == OP_MTLO)  lo_q <= cur_a;
                else if (state_q == S_FIX)   {hi_q, lo_q} <= {div_hi, div_lo};
                else                         {hi_q, lo_q} <= mul_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed corner bundles plus random bundles against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv_seq;
    localparam int NL = 2;
    localparam int XL = 32;
`ifdef MUL_FAST_EN
    localparam int MUL_COST = 1;
`else
    localparam int MUL_COST = XL;
`endif
    localparam int DIV_COST = XL + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        bundle_valid_i;
    logic [5:0]  lane_op_i;
    logic [63:0] lane_opa_i;
    logic [63:0] lane_opb_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        stallreq_o;
    logic        done_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    ex_muldiv_seq #(.NUM_LANES(NL), .XLEN(XL)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .bundle_valid_i (bundle_valid_i),
        .lane_op_i      (lane_op_i),
        .lane_opa_i     (lane_opa_i),
        .lane_opb_i     (lane_opb_i),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .busy_o         (busy_o),
        .stallreq_o     (stallreq_o),
        .done_o         (done_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sequential semantics of one lane, plus its stall cost
    function automatic void ref_lane(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] hi, inout logic [31:0] lo,
                                     inout int cost, inout bit md);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; cost += MUL_COST; md = 1; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; cost += MUL_COST; md = 1; end
            3'd3: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
                cost += DIV_COST; md = 1;
            end
            3'd4: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
                cost += DIV_COST; md = 1;
            end
            3'd5: begin hi = a; cost += 1; end
            3'd6: begin lo = a; cost += 1; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // entered mid-cycle with DUT idle; leaves mid-cycle once the bundle has fully committed
    task automatic run_bundle(input string tag, input logic [5:0] ops,
                              input logic [63:0] as, input logic [63:0] bs);
        logic [31:0] eh, el;
        int cost, cyc, dn, dat;
        bit md, last_done;
        eh = m_hi; el = m_lo; cost = 0; md = 0;
        for (int k = 0; k < NL; k++)
            ref_lane(ops[3*k +: 3], as[32*k +: 32], bs[32*k +: 32], eh, el, cost, md);
        if (!md) cost = 0;
        lane_op_i = ops; lane_opa_i = as; lane_opb_i = bs; bundle_valid_i = 1'b1;
        #2;
        cyc = 0; dn = 0; dat = 0;
        while (stallreq_o && cyc < 400) begin
            cyc++;
            last_done = done_o;
            if (done_o) begin dn++; dat = cyc; end
            @(posedge clk); #1;
            if (last_done) bundle_valid_i = 1'b0;
            else begin
                lane_op_i  = 6'($urandom);
                lane_opa_i = {$urandom, $urandom};
                lane_opb_i = {$urandom, $urandom};
            end
            #2;
        end
        if (cyc == 0) begin
            @(posedge clk); #1;
            bundle_valid_i = 1'b0;
            #2;
        end
        bundle_valid_i = 1'b0;
        check({tag, ".stall"}, cyc, cost);
        check({tag, ".done_cnt"}, dn, md ? 1 : 0);
        if (md) check({tag, ".done_pos"}, dat, cost);
        check({tag, ".hi"}, hi_o, eh);
        check({tag, ".lo"}, lo_o, el);
        check({tag, ".busy"}, busy_o, 0);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; bundle_valid_i = 1'b0;
        lane_op_i = '0; lane_opa_i = '0; lane_opb_i = '0;
        m_hi = 0; m_lo = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #2;
        check("rst.hi", hi_o, 0);
        check("rst.lo", lo_o, 0);
        check("rst.stall", stallreq_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);

        run_bundle("fast_hi", {3'd5, 3'd5}, {32'h22, 32'h11}, 64'd0);
        check("fast_hi.const", hi_o, 32'h22);
        run_bundle("fast_mix", {3'd5, 3'd6}, {32'h33, 32'h44}, 64'd0);

        run_bundle("div_neg", {3'd0, 3'd3}, {32'd0, 32'hFFFF_FFF9}, {32'd0, 32'd2});
        check("div_neg.lo_const", lo_o, 32'hFFFF_FFFD);
        check("div_neg.hi_const", hi_o, 32'hFFFF_FFFF);

        run_bundle("mul_ord", {3'd2, 3'd6}, {32'hFFFF_FFFF, 32'd5}, {32'd2, 32'd0});
        check("mul_ord.hi_const", hi_o, 32'd1);
        check("mul_ord.lo_const", lo_o, 32'hFFFF_FFFE);

        run_bundle("div_ovf", {3'd0, 3'd3}, {32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF});
        check("div_ovf.lo_const", lo_o, 32'h8000_0000);
        run_bundle("divu_zero", {3'd0, 3'd4}, {32'd0, 32'd9}, 64'd0);
        check("divu_zero.lo_const", lo_o, 32'hFFFF_FFFF);
        run_bundle("div_zero_neg", {3'd3, 3'd0}, {32'hFFFF_FFF0, 32'd0}, 64'd0);
        run_bundle("mult_neg", {3'd1, 3'd1}, {32'hFFFF_FFFD, 32'd7}, {32'd9, 32'hFFFF_FFFE});

        // flush at stall cycle 10, inside the lane1 divide
        lane_op_i = {3'd3, 3'd5}; lane_opa_i = {32'd100, 32'hAB}; lane_opb_i = {32'd7, 32'd0};
        bundle_valid_i = 1'b1;
        #2;
        check("flush.stall_on", stallreq_o, 1);
        for (int i = 2; i <= 10; i++) begin
            @(posedge clk); #1;
            bundle_valid_i = 1'b0;
            if (i == 10) flush_i = 1'b1;
            #2;
        end
        check("flush.stall_drop", stallreq_o, 0);
        check("flush.no_done", done_o, 0);
        @(posedge clk); #1; flush_i = 1'b0; #2;
        m_hi = 32'hAB;
        check("flush.hi", hi_o, m_hi);
        check("flush.lo", lo_o, m_lo);
        check("flush.busy", busy_o, 0);
        run_bundle("after_flush", {3'd0, 3'd4}, {32'd0, 32'd100}, {32'd0, 32'd7});

        // synchronous reset in the middle of a divide
        lane_op_i = {3'd0, 3'd3}; lane_opa_i = {32'd0, 32'd1000}; lane_opb_i = {32'd0, 32'd3};
        bundle_valid_i = 1'b1;
        #2;
        repeat (5) begin @(posedge clk); #1; bundle_valid_i = 1'b0; #2; end
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #2;
        check("mid_rst.hi", hi_o, 0);
        check("mid_rst.lo", lo_o, 0);
        check("mid_rst.stall", stallreq_o, 0);
        check("mid_rst.busy", busy_o, 0);
        m_hi = 0; m_lo = 0;

        for (int n = 0; n < 40; n++) begin
            logic [5:0]  ops;
            logic [63:0] as, bs;
            for (int k = 0; k < NL; k++) begin
                ops[3*k +: 3] = 3'($urandom_range(0, 7));
                as[32*k +: 32] = pick_operand();
                bs[32*k +: 32] = pick_operand();
            end
            run_bundle("rnd", ops, as, bs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Multi-cycle HI/LO execution sequencer shared by all issue lanes of the execute stage.
- Accepts one issue bundle of NUM_LANES lanes, each carrying a MULT/MULTU/DIV/DIVU/MTHI/MTLO/NOP op.
- Executes the ops serially in lane order using an internal iterative multiplier and radix-2 restoring divider.
- Owns the architectural HI/LO registers and asserts stallreq_o to freeze the pipeline while multi-cycle work is pending.

Parameters:
- NUM_LANES, 2, number of issue lanes in a bundle (1..4).
- XLEN, 32, operand width; HI and LO are each XLEN bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  abort the in-flight bundle (exception or branch squash).
- bundle_valid_i  in  1  bundle on lane inputs is valid.
- lane_op_i  in  3*NUM_LANES  per-lane op: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP. Lane k occupies bits [3k+2:3k].
- lane_opa_i  in  XLEN*NUM_LANES  per-lane rs operand.
- lane_opb_i  in  XLEN*NUM_LANES  per-lane rt operand.
- hi_o  out  XLEN  committed HI register.
- lo_o  out  XLEN  committed LO register.
- busy_o  out  1  FSM not in IDLE.
- stallreq_o  out  1  hold the bundle and the upstream pipeline.
- done_o  out  1  one-cycle pulse in the last cycle of a bundle's execution.

Behaviour:
- Reset: hi_o=0, lo_o=0, busy_o=0, stallreq_o=0, done_o=0; FSM in IDLE; all lane/iteration state cleared. Reset wins over every other input in the same cycle, including mid-operation.
- Lane order is program order (lane 0 oldest). Final HI/LO equals sequential execution lane 0..NUM_LANES-1.

Fast path (bundle with no MULT/MULTU/DIV/DIVU):
- MT ops apply at the next edge; no stall.
- Per register, the highest-index writing lane wins.
- done_o is not asserted.

Slow path (bundle with at least one mul/div op), FSM states IDLE, SLOT, MUL, DIV, FIX:
- Acceptance: in IDLE, bundle_valid_i & has_muldiv latches the whole bundle.
- Slot costs: NOP lanes cost 0 cycles. MT costs 1 cycle. MUL costs XLEN cycles (shift-add). DIV costs XLEN cycles (XLEN iterations) plus 1 FIX cycle for sign correction.
- The acceptance cycle is the first cycle of the first slot.
- stallreq_o is high for exactly S cycles, where S is the sum of slot costs. It is combinationally high in the acceptance cycle.
- Each op commits HI/LO at the edge ending its final cycle. Later lanes observe earlier lanes' results (MTHI followed by MULT: the MULT overwrites both).
- done_o is high in the last stalled cycle. The FSM returns to IDLE after that edge and may accept a new bundle in the next cycle.
- While stalled, inputs are ignored; the bundle is already latched.
- Result placement:
  - MULT/MULTU: {HI,LO} = full 2*XLEN product, signed or unsigned.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): LO = all ones, HI = dividend. Takes the normal DIV latency.
- Signed overflow: -2^(XLEN-1) / -1 gives LO = -2^(XLEN-1), HI = 0.

Flush and boundary cases:
- flush_i in any non-IDLE state: the current op is discarded without commit; ops already committed stay; return to IDLE next edge.
- flush_i with stallreq_o and done_o: stallreq_o drops the same cycle (combinational); no done_o pulse.
- flush_i in IDLE: the presented bundle is not accepted; the fast path does not commit.
- Simultaneous flush_i and the final cycle: flush wins; the final op is not committed.

Optional Feature:
- Macro: MUL_FAST_EN.
- Defined: MULT/MULTU use a single-cycle combinational multiplier; slot cost 1 cycle; the MUL state holds 1 cycle.
- Undefined: iterative shift-add multiplier with slot cost XLEN cycles.
- DIV timing and all other behaviour are identical in both builds.

Test Plan:
- Reset: rst held 2 cycles during an active DIV -> hi_o=0, lo_o=0, stallreq_o=0, busy_o=0 the cycle after rst releases.
- Fast path: lane0 MTHI 0x11, lane1 MTHI 0x22 + lane0 MTLO ... -> no stall; hi_o=0x22 next cycle.
- Signed DIV: lane0 DIV -7/2, lane1 NOP -> stallreq_o high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; done_o pulses in cycle 33.
- Ordered MUL: lane0 MTLO 5, lane1 MULTU 0xFFFFFFFF*2 -> iterative build stalls 33 cycles, fast build 2; HI=1, LO=0xFFFFFFFE.
- Corner divides: DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- Flush: flush_i at cycle 10 of a lane1 DIV after lane0 MTHI 0xAB -> stallreq_o drops the same cycle; HI=0xAB, LO unchanged; no done_o; a new bundle is accepted the next cycle.
